// File: rtl/alu_swap_pkg.sv
// Shared types and helpers for the nibble-swapping ALU byte queue.
package alu_swap_pkg;

    localparam int DATA_W = 8;
    localparam int NIB_W  = 4;

    typedef logic [DATA_W-1:0] byte_t;

    // Low nibble moves to the top: bit 7 comes from bit 3, bit 0 from bit 4.
    function automatic byte_t nibble_swap(input byte_t data);
        return {data[NIB_W-1:0], data[DATA_W-1:NIB_W]};
    endfunction

    function automatic logic even_parity(input byte_t data);
        return ^data;
    endfunction

endpackage

// File: rtl/alu_nibble_swap.sv
// Combinational nibble exchange applied to bytes on their way into the queue.
module alu_nibble_swap
    import alu_swap_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              swap,
    output logic [DATA_W-1:0] swapped
);

    assign swapped = swap ? nibble_swap(data) : data;

endmodule

// File: rtl/alu_swap_queue.sv
// Ready/valid byte FIFO with optional nibble swap at push.
// Define ALU_SWAP_QUEUE_PARITY_EN to store a per-entry even-parity bit and expose out_parity.
module alu_swap_queue
    import alu_swap_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_swap,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
`ifdef ALU_SWAP_QUEUE_PARITY_EN
    output logic                    out_parity,
`endif
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    byte_t            mem [DEPTH];
    byte_t            stored;
    logic             push;
    logic             pop;

    alu_nibble_swap u_swap (
        .data    (in_data),
        .swap    (in_swap),
        .swapped (stored)
    );

    // Flags derive from the registered count only, so reset clears them at once
    // and a full queue never accepts, even alongside a pop.
    assign in_ready  = count < CNT_W'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
    // increment wraps DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // update in this block sees pre-edge values.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; an entry is only
    // observable once count covers it, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= stored;
    end

`ifdef ALU_SWAP_QUEUE_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) par_mem[wr_ptr] <= even_parity(stored);
    end

    assign out_parity = out_valid && par_mem[rd_ptr];
`endif

endmodule

// File: doc/alu_swap_queue.md
ALU_SWAP_QUEUE -- requirements
Module: alu_swap_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two in 2..16.
REQ-002 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1, reset; asynchronous and active-high.
REQ-004 Port in_valid, input, 1, upstream byte offered.
REQ-005 Port in_ready, output, 1, queue accepts a byte this cycle.
REQ-006 Port in_data, input, 8, ALU data byte.
REQ-007 Port in_swap, input, 1, exchange nibbles of in_data before storage.
REQ-008 Port out_valid, output, 1, head entry available.
REQ-009 Port out_ready, input, 1, downstream consumes head.
REQ-010 Port out_data, output, 8, head entry.
REQ-011 Port count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-012 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-013 Stored byte SHALL be {in_data[3:0], in_data[7:4]} when in_swap=1, else in_data unchanged; bit 7 maps from bit 3, bit 0 maps from bit 4.
REQ-014 in_ready SHALL be 1 iff count < DEPTH; no bypass of a full queue, even with a simultaneous pop.
REQ-015 out_valid SHALL be 1 iff count > 0; out_data SHALL be the head entry when out_valid=1, else 8'h00.
REQ-016 Latency: a byte pushed on edge N SHALL appear on out_data after edge N when the queue was empty; no same-cycle flow-through.
REQ-017 Ordering SHALL be strict FIFO.
REQ-018 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-019 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 in_data and in_swap SHALL be ignored when no push occurs; out_ready SHALL be ignored when empty.
REQ-021 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or underflow.

Reset
REQ-022 Asserting rst SHALL immediately clear count and both pointers, drive out_valid=0, out_data=8'h00 and in_ready=1, regardless of the clock.
REQ-023 Reset mid-transfer SHALL discard all stored entries; storage contents need not be cleared.
REQ-024 The first push SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro ALU_SWAP_QUEUE_PARITY_EN defined: each entry SHALL store an even-parity bit, the XOR of the stored (post-swap) byte, computed at push.
REQ-026 With the macro defined, an extra output out_parity, 1 bit, SHALL present the head entry's parity bit, and SHALL be 0 when empty or in reset.
REQ-027 Macro undefined: out_parity and the parity storage SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package alu_swap_pkg SHALL hold DATA_W=8, NIB_W=4, the byte typedef and the nibble-swap function.
REQ-029 Combinational sub-module alu_nibble_swap (data in, swap enable, data out) SHALL implement REQ-013 and be instantiated once at the push side.
REQ-030 Storage SHALL be a register array indexed by $clog2(DEPTH)-bit pointers.

Verification
REQ-031 Reset, then push 8'hA5 with in_swap=1 -> next cycle out_valid=1, out_data=8'h5A, count=1.
REQ-032 Push 8'h12 with swap=0 and 8'h34 with swap=1, out_ready=1 -> out_data 8'h12 then 8'h43, count returns to 0.
REQ-033 With DEPTH=4, push 5 bytes and hold out_ready=0 -> in_ready=0 after 4 pushes, 5th byte not stored, count=4.
REQ-034 Full queue, in_valid=1 and out_ready=1 for one cycle -> pop only, count=3, in_ready=1 next cycle.
REQ-035 Continuous push and pop for 3*DEPTH cycles -> pointers wrap, order preserved, count stays at 1.
REQ-036 Assert rst asynchronously with count=3 -> out_valid=0, count=0 before the next edge; with ALU_SWAP_QUEUE_PARITY_EN, push 8'h07 -> out_parity=1.
